// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port unified instruction/data memory of the multicycle
// RISC-V core between the core port and a DMA/loader port. One non-pipelined
// access at a time; ties alternate against the previous owner.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; requests sampled here, grant latches mem_* regs
// ISSUE | mem_en high for this single cycle, latency counter loaded
// WAIT  | counting down the memory latency; read data captured at cnt==0
// DONE  | owner's done pulse is high; last_owner updated
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   core_req/we/addr/wdata        core request (held until core_done)
//   core_done, core_rdata         core completion pulse, read data register
//   dma_req/we/addr/wdata         DMA request (held until dma_done)
//   dma_done, dma_rdata           DMA completion pulse, read data register
//   mem_en, mem_we, mem_addr,     registered memory strobe / command
//   mem_wdata, mem_rdata          write data / read data from memory
//   busy                          high whenever the FSM is not in IDLE

module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_done,
    output logic [DW-1:0] core_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_DMA  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [3:0] cnt;
    logic       grant_dma;

    // DMA wins when it is the only requester, or on a tie when the core
    // owned the previous transaction.
    assign grant_dma = dma_req && (!core_req || (last_owner == OWN_CORE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CORE;
            last_owner <= OWN_DMA;
            cnt        <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_done  <= 1'b0;
            dma_done   <= 1'b0;
            core_rdata <= '0;
            dma_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            core_done <= 1'b0;
            dma_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (core_req || dma_req) begin
                        if (grant_dma) begin
                            owner     <= OWN_DMA;
                            mem_we    <= dma_we;
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                        end else begin
                            owner     <= OWN_CORE;
                            mem_we    <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end

                WAIT: begin
                    if (cnt == 4'd0) begin
                        // mem_rdata is valid in exactly this cycle; writes
                        // leave the rdata registers untouched.
                        if (!mem_we) begin
                            if (owner == OWN_DMA) begin
                                dma_rdata <= mem_rdata;
                            end else begin
                                core_rdata <= mem_rdata;
                            end
                        end
                        if (owner == OWN_DMA) begin
                            dma_done <= 1'b1;
                        end else begin
                            core_done <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Instance 0 (MEM_LAT=2) runs the main
// sequence with a completion scoreboard; instances 1 and 2 (MEM_LAT=1 and
// MEM_LAT=15) check latency extremes. Each instance has a memory model that
// drives valid read data only in the single cycle the arbiter must sample it.

module tb_mem_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        core_req   [NI];
    logic        core_we    [NI];
    logic [31:0] core_addr  [NI];
    logic [31:0] core_wdata [NI];
    logic        core_done  [NI];
    logic [31:0] core_rdata [NI];
    logic        dma_req    [NI];
    logic        dma_we     [NI];
    logic [31:0] dma_addr   [NI];
    logic [31:0] dma_wdata  [NI];
    logic        dma_done   [NI];
    logic [31:0] dma_rdata  [NI];
    logic        mem_en     [NI];
    logic        mem_we     [NI];
    logic [31:0] mem_addr   [NI];
    logic [31:0] mem_wdata  [NI];
    logic [31:0] mem_rdata  [NI];
    logic        busy       [NI];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          port;   // 0 = core, 1 = DMA
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem_arr [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_default(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(a));
    endfunction

    function automatic logic [31:0] mem_read(input logic [7:0] a);
        return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : mem_default(a);
    endfunction

    // Only instance 0 ever writes.
    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) mem_arr[int'(mem_addr[0][7:0])] = mem_wdata[0];
    end

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int LAT = (i == 0) ? 2 : ((i == 1) ? 1 : 15);

        int          rd_pend = -1;
        logic [31:0] rd_val  = 32'h0;

        always @(posedge clk) begin
            if (rd_pend >= 0) rd_pend--;
            if (mem_en[i] && !mem_we[i]) begin
                rd_pend = LAT - 1;
                rd_val  = mem_read(mem_addr[i][7:0]);
            end
            mem_rdata[i] <= (rd_pend == 0) ? rd_val : 32'hBAD0BAD0;
        end

        mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .core_req   (core_req[i]),
            .core_we    (core_we[i]),
            .core_addr  (core_addr[i]),
            .core_wdata (core_wdata[i]),
            .core_done  (core_done[i]),
            .core_rdata (core_rdata[i]),
            .dma_req    (dma_req[i]),
            .dma_we     (dma_we[i]),
            .dma_addr   (dma_addr[i]),
            .dma_wdata  (dma_wdata[i]),
            .dma_done   (dma_done[i]),
            .dma_rdata  (dma_rdata[i]),
            .mem_en     (mem_en[i]),
            .mem_we     (mem_we[i]),
            .mem_addr   (mem_addr[i]),
            .mem_wdata  (mem_wdata[i]),
            .mem_rdata  (mem_rdata[i]),
            .busy       (busy[i])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit port, input int c, input logic [31:0] d);
        exp_t e;
        e.port  = port;
        e.cyc   = c;
        e.rdata = d;
        sb.push_back(e);
    endtask

    // Completion monitor for instance 0: every done pulse must match the
    // oldest outstanding expectation in port, cycle and read data.
    always @(negedge clk) begin
        if (core_done[0] || dma_done[0]) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_done: observed core=%0b dma=%0b at cycle %0d expected no done",
                       core_done[0], dma_done[0], cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_port", {62'd0, dma_done[0], core_done[0]}, e.port ? 64'd2 : 64'd1);
                check("sb_cycle", 64'(cyc), 64'(e.cyc));
                check("sb_rdata", e.port ? dma_rdata[0] : core_rdata[0], e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_en"},     mem_en[0],     0);
        check({tag, "_mem_we"},     mem_we[0],     0);
        check({tag, "_mem_addr"},   mem_addr[0],   0);
        check({tag, "_mem_wdata"},  mem_wdata[0],  0);
        check({tag, "_core_done"},  core_done[0],  0);
        check({tag, "_dma_done"},   dma_done[0],   0);
        check({tag, "_core_rdata"}, core_rdata[0], 0);
        check({tag, "_dma_rdata"},  dma_rdata[0],  0);
        check({tag, "_busy"},       busy[0],       0);
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        tick();
        tick();
        check_reset(tag);
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        int n_en;
        int en_c [NI];
        int dn_c [NI];
        int en_n [NI];
        logic [31:0] rd_c [NI];
        logic [31:0] last_dma;

        for (int i = 0; i < NI; i++) begin
            core_req[i] = 0; core_we[i] = 0; core_addr[i] = 0; core_wdata[i] = 0;
            dma_req[i]  = 0; dma_we[i]  = 0; dma_addr[i]  = 0; dma_wdata[i]  = 0;
            en_c[i] = -1; dn_c[i] = -1; en_n[i] = 0; rd_c[i] = 0;
        end

        reset_dut("rst0");

        // Single core read of 0x10.
        tick();
        core_addr[0] = 32'h10; core_we[0] = 0; core_req[0] = 1;
        t0 = cyc;
        push_exp(0, t0 + 4, 32'hDEADBEEF);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) core_req[0] = 0;
            check("rd_mem_en", mem_en[0], k == 1);
            if (k == 1) begin
                check("rd_mem_addr", mem_addr[0], 32'h10);
                check("rd_mem_we",   mem_we[0],   0);
            end
            check("rd_busy", busy[0], k <= 4);
        end

        // Contention: four completions alternating core, DMA, core, DMA.
        reset_dut("rst1");
        tick();
        core_addr[0] = 32'h10; core_we[0] = 0; core_req[0] = 1;
        dma_addr[0]  = 32'h30; dma_we[0]  = 0; dma_req[0]  = 1;
        t0 = cyc;
        push_exp(0, t0 + 4,  32'hDEADBEEF);
        push_exp(1, t0 + 9,  mem_default(8'h30));
        push_exp(0, t0 + 14, 32'hDEADBEEF);
        push_exp(1, t0 + 19, mem_default(8'h30));
        last_dma = mem_default(8'h30);
        while (cyc < t0 + 21) begin
            tick();
            if (cyc == t0 + 15) core_req[0] = 0;
            if (cyc == t0 + 20) dma_req[0]  = 0;
        end
        check("cont_busy_end", busy[0], 0);

        // DMA write, then core read-back of the same address.
        tick();
        dma_addr[0] = 32'h20; dma_we[0] = 1; dma_wdata[0] = 32'h12345678; dma_req[0] = 1;
        t0 = cyc;
        push_exp(1, t0 + 4, last_dma);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) begin dma_req[0] = 0; dma_we[0] = 0; end
            check("wr_mem_en", mem_en[0], k == 1);
            if (k == 1) begin
                check("wr_mem_we",    mem_we[0],    1);
                check("wr_mem_addr",  mem_addr[0],  32'h20);
                check("wr_mem_wdata", mem_wdata[0], 32'h12345678);
            end
        end
        tick();
        core_addr[0] = 32'h20; core_we[0] = 0; core_req[0] = 1;
        t0 = cyc;
        push_exp(0, t0 + 4, 32'h12345678);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) core_req[0] = 0;
        end

        // Core requesting continuously for three transactions.
        tick();
        core_addr[0] = 32'h44; core_req[0] = 1;
        t0 = cyc;
        push_exp(0, t0 + 4,  mem_default(8'h44));
        push_exp(0, t0 + 9,  mem_default(8'h44));
        push_exp(0, t0 + 14, mem_default(8'h44));
        n_en = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (mem_en[0]) n_en++;
            if (k == 15) core_req[0] = 0;
        end
        check("burst_mem_en_count", 64'(n_en), 3);

        // Request dropped after one cycle still completes.
        tick();
        core_addr[0] = 32'h30; core_req[0] = 1;
        t0 = cyc;
        push_exp(0, t0 + 4, mem_default(8'h30));
        tick();
        core_req[0] = 0;
        for (int k = 2; k <= 5; k++) tick();
        check("drop_busy_end", busy[0], 0);

        // Reset during WAIT aborts the read; core wins the tie afterwards.
        tick();
        core_addr[0] = 32'h10; core_req[0] = 1;
        t0 = cyc;
        tick();
        tick();
        check("abort_busy_wait", busy[0], 1);
        rst = 1'b1;
        tick();
        check_reset("abort");
        rst = 1'b0;
        dma_addr[0] = 32'h30; dma_we[0] = 0; dma_req[0] = 1;
        t1 = cyc;
        push_exp(0, t1 + 4, 32'hDEADBEEF);
        push_exp(1, t1 + 9, mem_default(8'h30));
        while (cyc < t1 + 10) begin
            tick();
            if (cyc == t1 + 5)  core_req[0] = 0;
            if (cyc == t1 + 10) dma_req[0]  = 0;
        end
        tick();
        check("abort_busy_end", busy[0], 0);

        // Latency extremes on instances 1 (MEM_LAT=1) and 2 (MEM_LAT=15).
        tick();
        core_addr[1] = 32'h10; core_req[1] = 1;
        core_addr[2] = 32'h10; core_req[2] = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int i = 1; i < NI; i++) begin
                if (mem_en[i]) begin
                    en_n[i]++;
                    if (en_c[i] < 0) en_c[i] = k;
                end
                if (core_done[i] && dn_c[i] < 0) begin
                    dn_c[i] = k;
                    rd_c[i] = core_rdata[i];
                end
            end
            if (k == 4)  core_req[1] = 0;
            if (k == 18) core_req[2] = 0;
        end
        check("lat1_mem_en_cycle",  64'(en_c[1]), 1);
        check("lat1_done_cycle",    64'(dn_c[1]), 3);
        check("lat1_rdata",         rd_c[1],      32'hDEADBEEF);
        check("lat1_mem_en_count",  64'(en_n[1]), 1);
        check("lat15_mem_en_cycle", 64'(en_c[2]), 1);
        check("lat15_done_cycle",   64'(dn_c[2]), 17);
        check("lat15_rdata",        rd_c[2],      32'hDEADBEEF);
        check("lat15_mem_en_count", 64'(en_n[2]), 1);
        check("lat15_dma_done",     dma_done[2],  0);

        tick();
        check("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
